// File: rtl/airi5c_pcpi_hub_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | airi5c_pcpi_hub_if                                                         |
// | PCPI bundle between the core, the hub and N_COP coprocessors.              |
// |   core_*  : core-side PCPI (valid/insn/rs1/rs2 in, wr/rd/wait/ready out,   |
// |             plus illegal/timeout pulses)                                   |
// |   cop_*   : coprocessor side; per-port valid/wr/wait/ready vectors,        |
// |             broadcast insn/rs1/rs2, packed per-port results                |
// |   slave   : hub view        master : core + coprocessor environment view   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface airi5c_pcpi_hub_if #(
  parameter int N_COP   = 4,
  parameter int XPR_LEN = 32
);
  logic                     core_valid;
  logic [XPR_LEN-1:0]       core_insn;
  logic [XPR_LEN-1:0]       core_rs1;
  logic [XPR_LEN-1:0]       core_rs2;
  logic                     core_wr;
  logic [XPR_LEN-1:0]       core_rd;
  logic                     core_wait;
  logic                     core_ready;
  logic                     core_illegal;
  logic                     core_timeout;

  logic [N_COP-1:0]         cop_valid;
  logic [XPR_LEN-1:0]       cop_insn;
  logic [XPR_LEN-1:0]       cop_rs1;
  logic [XPR_LEN-1:0]       cop_rs2;
  logic [N_COP-1:0]         cop_wr;
  logic [N_COP-1:0]         cop_wait;
  logic [N_COP-1:0]         cop_ready;
  logic [N_COP*XPR_LEN-1:0] cop_rd;

  modport slave (
    input  core_valid, core_insn, core_rs1, core_rs2,
    input  cop_wr, cop_wait, cop_ready, cop_rd,
    output core_wr, core_rd, core_wait, core_ready, core_illegal, core_timeout,
    output cop_valid, cop_insn, cop_rs1, cop_rs2
  );

  modport master (
    output core_valid, core_insn, core_rs1, core_rs2,
    output cop_wr, cop_wait, cop_ready, cop_rd,
    input  core_wr, core_rd, core_wait, core_ready, core_illegal, core_timeout,
    input  cop_valid, cop_insn, cop_rs1, cop_rs2
  );
endinterface
`default_nettype wire

// File: rtl/airi5c_pcpi_hub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | airi5c_pcpi_hub                                                            |
// | Dispatches offloaded PCPI instructions from the core to N_COP              |
// | coprocessors, locks onto the lowest-index claimant and returns its result  |
// | through a registered one-cycle response. Flags illegal instructions (no    |
// | claim within CLAIM_TIMEOUT cycles) and hung owners (BUSY_TIMEOUT).         |
// | Ports:                                                                     |
// |   clk    : clock                                                           |
// |   nreset : asynchronous active-low reset                                   |
// |   bus    : airi5c_pcpi_hub_if.slave (core side + coprocessor side)         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module airi5c_pcpi_hub #(
  parameter int               N_COP         = 4,
  parameter int               XPR_LEN       = 32,
  parameter logic [N_COP-1:0] EN_MASK       = {N_COP{1'b1}},
  parameter int               CLAIM_TIMEOUT = 8,
  parameter int               BUSY_TIMEOUT  = 1024
) (
  input wire               clk,
  input wire               nreset,
  airi5c_pcpi_hub_if.slave bus
);

  localparam int OW = (N_COP > 1) ? $clog2(N_COP) : 1;
  localparam int CW = 16;
  localparam int BW = $clog2(BUSY_TIMEOUT + 2);
  localparam logic [CW-1:0] CLAIM_LIM = CW'(CLAIM_TIMEOUT);
  localparam logic [BW-1:0] BUSY_LIM  = BW'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_RESP  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t             state_q;
  logic [OW-1:0]      owner_q;
  logic [CW-1:0]      claim_cnt_q;
  logic [BW-1:0]      busy_cnt_q;
  logic               ready_q;
  logic               wr_q;
  logic [XPR_LEN-1:0] rd_q;
  logic               illegal_q;
  logic               timeout_q;

  logic [N_COP-1:0]   w_cop_valid;
  logic [N_COP-1:0]   w_owner_onehot;
  logic [N_COP-1:0]   w_claim;
  logic [OW-1:0]      w_claim_idx;
  logic [OW-1:0]      w_sel;
  logic               w_sel_wr;
  logic               w_sel_ready;
  logic [XPR_LEN-1:0] w_sel_rd;

  // Kept apart from the result mux so the valid -> claim -> select path
  // does not look like a loop through a shared block.
  always_comb begin
    w_owner_onehot = '0;
    for (int i = 0; i < N_COP; i++) begin
      if (OW'(i) == owner_q) w_owner_onehot[i] = 1'b1;
    end
  end

  // Gated by nreset so the coprocessors see nothing while the hub is held
  // in reset, even if the core keeps core_valid high.
  always_comb begin
    w_cop_valid = '0;
    if (nreset) begin
      case (state_q)
        S_IDLE:  w_cop_valid = EN_MASK & {N_COP{bus.core_valid}};
        S_BUSY:  w_cop_valid = w_owner_onehot & {N_COP{bus.core_valid}};
        default: w_cop_valid = '0;
      endcase
    end
  end

  // A wait/ready only counts as a claim on a port that is currently offered
  // the instruction.
  assign w_claim = (bus.cop_wait | bus.cop_ready) & w_cop_valid;

  // Lowest index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    w_claim_idx = '0;
    for (int i = N_COP - 1; i >= 0; i--) begin
      if (w_claim[i]) w_claim_idx = OW'(i);
    end
  end

  assign w_sel = (state_q == S_BUSY) ? owner_q : w_claim_idx;

  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_ready = 1'b0;
    w_sel_rd    = '0;
    for (int i = 0; i < N_COP; i++) begin
      if (OW'(i) == w_sel) begin
        w_sel_wr    = bus.cop_wr[i];
        w_sel_ready = bus.cop_ready[i];
        w_sel_rd    = bus.cop_rd[i*XPR_LEN +: XPR_LEN];
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      claim_cnt_q <= '0;
      busy_cnt_q  <= '0;
      ready_q     <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= '0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      // Response registers are pulses: only the transition into RESP sets them.
      ready_q   <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|w_claim) begin
            owner_q     <= w_claim_idx;
            claim_cnt_q <= '0;
            busy_cnt_q  <= '0;
            if (w_sel_ready) begin
              ready_q <= 1'b1;
              wr_q    <= w_sel_wr;
              rd_q    <= w_sel_wr ? w_sel_rd : '0;
              state_q <= S_RESP;
            end else begin
              state_q <= S_BUSY;
            end
          end else if (bus.core_valid) begin
            claim_cnt_q <= claim_cnt_q + CW'(1);
            if (claim_cnt_q + CW'(1) == CLAIM_LIM) begin
              illegal_q <= 1'b1;
              state_q   <= S_RESP;
            end
          end else begin
            claim_cnt_q <= '0;
          end
        end
        S_BUSY: begin
          // Abort has priority over a same-cycle ready from the owner.
          if (!bus.core_valid) begin
            claim_cnt_q <= '0;
            busy_cnt_q  <= '0;
            state_q     <= S_IDLE;
          end else if (w_sel_ready) begin
            ready_q <= 1'b1;
            wr_q    <= w_sel_wr;
            rd_q    <= w_sel_wr ? w_sel_rd : '0;
            state_q <= S_RESP;
          end else begin
            busy_cnt_q <= busy_cnt_q + BW'(1);
            if ((BUSY_TIMEOUT != 0) && (busy_cnt_q + BW'(1) == BUSY_LIM)) begin
              timeout_q <= 1'b1;
              state_q   <= S_RESP;
            end
          end
        end
        S_RESP: begin
          state_q <= S_DRAIN;
        end
        default: begin
          // DRAIN: swallow the cycle in which the core drops core_valid.
          claim_cnt_q <= '0;
          busy_cnt_q  <= '0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cop_valid    = w_cop_valid;
  assign bus.cop_insn     = bus.core_insn;
  assign bus.cop_rs1      = bus.core_rs1;
  assign bus.cop_rs2      = bus.core_rs2;
  assign bus.core_wait    = (state_q == S_BUSY) || ((state_q == S_IDLE) && (|w_claim));
  assign bus.core_ready   = ready_q;
  assign bus.core_wr      = wr_q;
  assign bus.core_rd      = rd_q;
  assign bus.core_illegal = illegal_q;
  assign bus.core_timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_airi5c_pcpi_hub.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_airi5c_pcpi_hub                                                         |
// | Directed self-checking bench for airi5c_pcpi_hub (N_COP=4, XPR_LEN=32,     |
// | CLAIM_TIMEOUT=8, BUSY_TIMEOUT=16). Coprocessor behaviour is driven by hand |
// | cycle by cycle; cycle numbers below count from the cycle core_valid rises. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_airi5c_pcpi_hub;
  localparam int N  = 4;
  localparam int XL = 32;

  logic clk    = 1'b0;
  logic nreset = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  airi5c_pcpi_hub_if #(.N_COP(N), .XPR_LEN(XL)) bus ();

  airi5c_pcpi_hub #(
    .N_COP(N), .XPR_LEN(XL), .EN_MASK(4'b1111),
    .CLAIM_TIMEOUT(8), .BUSY_TIMEOUT(16)
  ) dut (
    .clk(clk), .nreset(nreset), .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.core_valid = 1'b0;
    bus.core_insn  = '0;
    bus.core_rs1   = '0;
    bus.core_rs2   = '0;
    bus.cop_wait   = '0;
    bus.cop_ready  = '0;
    bus.cop_wr     = '0;
    bus.cop_rd     = '0;
  endtask

  task automatic set_rd(input int p, input logic [XL-1:0] v);
    bus.cop_rd[p*XL +: XL] = v;
  endtask

  initial begin
    quiet();
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", bus.core_ready, 0);
    chk("rst_wait", bus.core_wait, 0);
    chk("rst_rd", bus.core_rd, 0);
    chk("rst_flags", {bus.core_wr, bus.core_illegal, bus.core_timeout}, 0);
    nreset = 1'b1;

    // T1: unit on port 0, rs1=1, ready in cycle 2 -> core_ready in cycle 3
    step(); bus.core_valid = 1'b1; bus.core_insn = 32'h0000_000B; bus.core_rs1 = 32'h1;
    bus.cop_wait = 4'b0001; #1;
    chk("t1_fanout_c0", bus.cop_valid, 4'b1111);
    chk("t1_bcast_rs1", bus.cop_rs1, 32'h1);
    chk("t1_wait_c0", bus.core_wait, 1);
    step(); #1;
    chk("t1_owner_only_c1", bus.cop_valid, 4'b0001);
    chk("t1_wait_c1", bus.core_wait, 1);
    step(); bus.cop_wait = '0; bus.cop_ready = 4'b0001; bus.cop_wr = 4'b0001;
    set_rd(0, 32'h8000_0000); #1;
    chk("t1_noready_c2", bus.core_ready, 0);
    step(); bus.cop_ready = '0; bus.cop_wr = '0; #1;
    chk("t1_ready_c3", bus.core_ready, 1);
    chk("t1_wr_c3", bus.core_wr, 1);
    chk("t1_rd_c3", bus.core_rd, 32'h8000_0000);
    chk("t1_copvalid_c3", bus.cop_valid, 0);
    chk("t1_wait_c3", bus.core_wait, 0);
    step(); quiet(); #1;
    chk("t1_drain_c4", {bus.core_ready, bus.core_wr, bus.core_rd}, 0);

    // T2: nobody claims -> core_illegal in cycle 8
    step(); bus.core_valid = 1'b1; bus.core_insn = 32'h0000_007F; #1;
    chk("t2_fanout_c0", bus.cop_valid, 4'b1111);
    repeat (7) step();
    #1;
    chk("t2_noillegal_c7", bus.core_illegal, 0);
    step(); #1;
    chk("t2_illegal_c8", bus.core_illegal, 1);
    chk("t2_noready_c8", bus.core_ready, 0);
    chk("t2_rd_c8", bus.core_rd, 0);
    chk("t2_copvalid_c8", bus.cop_valid, 0);
    step(); quiet(); #1;
    chk("t2_pulse_end_c9", bus.core_illegal, 0);

    // T3: ports 1 and 2 claim together; port 1 owns, port 2's ready is ignored
    step(); bus.core_valid = 1'b1; bus.core_insn = 32'h0000_002B;
    bus.cop_wait = 4'b0110; #1;
    chk("t3_wait_c0", bus.core_wait, 1);
    step(); bus.cop_ready = 4'b0110; bus.cop_wr = 4'b0110;
    set_rd(1, 32'h1234_5678); set_rd(2, 32'hDEAD_BEEF); #1;
    chk("t3_loser_dropped_c1", bus.cop_valid, 4'b0010);
    step(); bus.cop_wait = '0; bus.cop_ready = '0; bus.cop_wr = '0; #1;
    chk("t3_ready_c2", bus.core_ready, 1);
    chk("t3_rd_c2", bus.core_rd, 32'h1234_5678);
    step(); quiet();

    // T4: port 3 holds wait; 16 BUSY cycles after the claim cycle -> timeout
    step(); bus.core_valid = 1'b1; bus.cop_wait = 4'b1000; #1;
    chk("t4_wait_c0", bus.core_wait, 1);
    repeat (16) step();
    #1;
    chk("t4_notimeout_c16", bus.core_timeout, 0);
    chk("t4_wait_c16", bus.core_wait, 1);
    step(); #1;
    chk("t4_timeout_c17", bus.core_timeout, 1);
    chk("t4_noready_c17", {bus.core_ready, bus.core_wr}, 0);
    step(); quiet(); #1;
    chk("t4_pulse_end_c18", bus.core_timeout, 0);
    // follow-up: zero-latency unit on port 3
    step(); bus.core_valid = 1'b1; bus.cop_wait = 4'b1000; bus.cop_ready = 4'b1000;
    bus.cop_wr = 4'b1000; set_rd(3, 32'hA5A5_A5A5); #1;
    chk("t4_next_fanout", bus.cop_valid, 4'b1111);
    step(); bus.cop_wait = '0; bus.cop_ready = '0; bus.cop_wr = '0; #1;
    chk("t4_next_ready", bus.core_ready, 1);
    chk("t4_next_rd", bus.core_rd, 32'hA5A5_A5A5);
    step(); quiet();

    // T5: core drops valid in BUSY cycle 2 while owner raises ready -> abort
    step(); bus.core_valid = 1'b1; bus.cop_wait = 4'b0001;
    step();
    step(); bus.core_valid = 1'b0; bus.cop_ready = 4'b0001; bus.cop_wr = 4'b0001;
    set_rd(0, 32'h0000_0055); #1;
    chk("t5_copvalid_abort", bus.cop_valid, 0);
    step(); quiet(); bus.core_valid = 1'b1; bus.core_insn = 32'h0000_005B; #1;
    chk("t5_no_response", {bus.core_ready, bus.core_illegal, bus.core_timeout}, 0);
    chk("t5_idle_fanout", bus.cop_valid, 4'b1111);
    repeat (7) step();
    #1;
    chk("t5_noillegal_w7", bus.core_illegal, 0);
    step(); #1;
    chk("t5_illegal_w8", bus.core_illegal, 1);
    step(); quiet();

    // T6: reset while BUSY, then back-to-back instructions
    step(); bus.core_valid = 1'b1; bus.cop_wait = 4'b0010;
    step(); #1;
    chk("t6_busy_wait", bus.core_wait, 1);
    nreset = 1'b0; #1;
    chk("t6_rst_wait", bus.core_wait, 0);
    chk("t6_rst_copvalid", bus.cop_valid, 0);
    chk("t6_rst_ready", {bus.core_ready, bus.core_illegal, bus.core_timeout}, 0);
    quiet();
    step(); step(); nreset = 1'b1;
    bus.core_valid = 1'b1; bus.cop_wait = 4'b0001; bus.cop_ready = 4'b0001;
    bus.cop_wr = 4'b0001; set_rd(0, 32'h1111_1111); #1;
    chk("t6_a_wait", bus.core_wait, 1);
    step(); bus.cop_wait = '0; bus.cop_ready = '0; bus.cop_wr = '0; #1;
    chk("t6_a_ready", bus.core_ready, 1);
    chk("t6_a_rd", bus.core_rd, 32'h1111_1111);
    step(); quiet();
    step(); bus.core_valid = 1'b1; bus.cop_wait = 4'b0100;
    step(); bus.cop_wait = '0; bus.cop_ready = 4'b0100; bus.cop_wr = 4'b0100;
    set_rd(2, 32'h2222_2222);
    step(); bus.cop_ready = '0; bus.cop_wr = '0; #1;
    chk("t6_b_ready", bus.core_ready, 1);
    chk("t6_b_rd", bus.core_rd, 32'h2222_2222);
    step(); quiet();
    // unit answers without write-back: rd must read as 0
    step(); bus.core_valid = 1'b1; bus.cop_wait = 4'b0010; bus.cop_ready = 4'b0010;
    bus.cop_wr = '0; set_rd(1, 32'hFFFF_FFFF);
    step(); bus.cop_wait = '0; bus.cop_ready = '0; #1;
    chk("t6_c_ready", bus.core_ready, 1);
    chk("t6_c_wr_rd", {bus.core_wr, bus.core_rd}, 0);
    step(); quiet();
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire
